acc_ctrl: RTL and testbench

Instruction sequencer that sits directly upstream of the 4-bit accumulator register and the 8-function ALU. It accepts 8-bit instructions over a valid/ready handshake. For each one it drives one-cycle register control strobes, the register data input and the ALU opcode/B operand, holding them for as many cycles as the instruction needs. It closes the datapath loop by routing the ALU result back into the register load path.

---
 rtl/acc_ctrl.sv | 116 +++++++++++
 tb/tb_acc_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// Instruction sequencer for the 4-bit accumulator register and 8-function ALU.
// Accepts {op, imm} over valid/ready and drives one-cycle register strobes per execution cycle.
module acc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [7:0] instr,
    input  logic [3:0] acc,
    input  logic [3:0] alu_f,
    output logic [2:0] alu_oc,
    output logic [3:0] alu_b,
    output logic       reg_cl,
    output logic       reg_ld,
    output logic       reg_inc,
    output logic       reg_dec,
    output logic       reg_sr,
    output logic       reg_sl,
    output logic       reg_ir,
    output logic       reg_il,
    output logic [3:0] reg_in,
    output logic       done,
    output logic       illegal,
    output logic [7:0] retired
);
    localparam logic [3:0] OP_NOP = 4'h0, OP_CLR = 4'h1, OP_LDI = 4'h2, OP_INC = 4'h3,
                           OP_DEC = 4'h4, OP_SHR = 4'h5, OP_SHL = 4'h6, OP_LDB = 4'h7,
                           OP_ALU = 4'h8, OP_RPI = 4'h9, OP_RPD = 4'hA;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t     state, state_nx;
    logic [3:0] op_q, imm_q, cnt_q, cnt_init, b_q;
    logic       hs;
    logic       unused_acc;

    // acc is observation only; sequencing never depends on it.
    assign unused_acc  = ^acc;
    assign instr_ready = (state == IDLE) && rst_n;
    assign hs          = instr_valid && instr_ready;
    assign alu_b       = b_q;

    // cnt holds remaining cycles minus one; a zero-length repeat still takes one cycle.
    always_comb begin
        cnt_init = 4'd0;
        case (instr[7:4])
            OP_SHR, OP_SHL: cnt_init = {2'b00, instr[1:0]};
            OP_RPI, OP_RPD: cnt_init = (instr[3:0] == 4'd0) ? 4'd0 : instr[3:0] - 4'd1;
            default:        cnt_init = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        reg_cl   = 1'b0;
        reg_ld   = 1'b0;
        reg_inc  = 1'b0;
        reg_dec  = 1'b0;
        reg_sr   = 1'b0;
        reg_sl   = 1'b0;
        reg_ir   = 1'b0;
        reg_il   = 1'b0;
        reg_in   = 4'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state)
            IDLE: if (hs) state_nx = EXEC;
            EXEC: begin
                done = (cnt_q == 4'd0);
                if (done) state_nx = IDLE;
                case (op_q)
                    OP_NOP, OP_LDB: ;
                    OP_CLR: reg_cl = 1'b1;
                    OP_LDI: begin reg_ld = 1'b1; reg_in = imm_q; end
                    OP_INC: reg_inc = 1'b1;
                    OP_DEC: reg_dec = 1'b1;
                    OP_SHR: begin reg_sr = 1'b1; reg_il = imm_q[2]; end
                    OP_SHL: begin reg_sl = 1'b1; reg_ir = imm_q[2]; end
                    OP_ALU: begin reg_ld = 1'b1; reg_in = alu_f; end
                    OP_RPI: reg_inc = (imm_q != 4'd0);
                    OP_RPD: reg_dec = (imm_q != 4'd0);
                    default: illegal = 1'b1;
                endcase
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= 4'd0;
            imm_q   <= 4'd0;
            cnt_q   <= 4'd0;
            b_q     <= 4'd0;
            alu_oc  <= 3'd0;
            retired <= 8'd0;
        end else begin
            if (hs) begin
                op_q  <= instr[7:4];
                imm_q <= instr[3:0];
                cnt_q <= cnt_init;
                // Registering the opcode at the handshake lets alu_f settle inside the execution cycle.
                if (instr[7:4] == OP_ALU) alu_oc <= instr[2:0];
            end else if (state == EXEC) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state == EXEC && op_q == OP_LDB) b_q <= imm_q;
            if (done) retired <= retired + 8'd1;
        end
    end
endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl: an instruction-expansion model checked every cycle, plus literal checks.
module tb_acc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr = 8'd0;
    logic [3:0] acc = 4'd5;
    logic [3:0] alu_f = 4'd0;
    logic [2:0] alu_oc;
    logic [3:0] alu_b;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
    logic [3:0] reg_in;
    logic       done, illegal;
    logic [7:0] retired;

    acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .acc(acc), .alu_f(alu_f), .alu_oc(alu_oc), .alu_b(alu_b),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
        .reg_in(reg_in), .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // One expected execution cycle: strobes {cl,ld,inc,dec,sr,sl}; in_sel 1=imm, 2=alu_f.
    typedef struct packed {
        logic [5:0] stb;
        logic       ir, il;
        logic [1:0] in_sel;
        logic [3:0] imm;
        logic       done, ill, ldb;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_ret;
    logic [3:0] m_b;
    logic [2:0] m_oc;
    bit         started = 0;
    int         errors = 0, checks = 0;
    int         n_ld, n_inc, n_dec, n_sl, n_done, n_ill, n_stb;
    logic [3:0] last_ld_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void expand(input logic [7:0] i);
        logic [3:0] op, im;
        int n;
        ent_t e;
        op = i[7:4];
        im = i[3:0];
        n  = 1;
        e  = '0;
        e.imm = im;
        case (op)
            4'h1: e.stb = 6'b100000;
            4'h2: begin e.stb = 6'b010000; e.in_sel = 2'd1; end
            4'h3: e.stb = 6'b001000;
            4'h4: e.stb = 6'b000100;
            4'h5: begin e.stb = 6'b000010; e.il = im[2]; n = im[1:0] + 1; end
            4'h6: begin e.stb = 6'b000001; e.ir = im[2]; n = im[1:0] + 1; end
            4'h7: e.ldb = 1'b1;
            4'h8: begin e.stb = 6'b010000; e.in_sel = 2'd2; end
            4'h9: begin n = (im == 0) ? 1 : im; if (im != 0) e.stb = 6'b001000; end
            4'hA: begin n = (im == 0) ? 1 : im; if (im != 0) e.stb = 6'b000100; end
            4'h0: ;
            default: e.ill = 1'b1;
        endcase
        for (int k = 0; k < n; k++) begin
            e.done = (k == n - 1);
            q.push_back(e);
        end
    endfunction

    task automatic mdl_step();
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_ret = 8'd0;
            m_b = 4'd0;
            m_oc = 3'd0;
            started = 1;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            if (e.done) m_ret++;
            if (e.ldb) m_b = e.imm;
        end else if (instr_valid && started) begin
            expand(instr);
            if (instr[7:4] == 4'h8) m_oc = instr[2:0];
        end
    endtask

    task automatic cmp();
        ent_t e;
        logic [3:0] exp_in;
        if (!started) return;
        e = (q.size() != 0) ? q[0] : '0;
        exp_in = (e.in_sel == 2'd1) ? e.imm : (e.in_sel == 2'd2) ? alu_f : 4'd0;
        chk("ready", instr_ready, (rst_n && q.size() == 0) ? 1 : 0);
        chk("strobes", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}, e.stb);
        chk("ir_il", {reg_ir, reg_il}, {e.ir, e.il});
        chk("reg_in", reg_in, exp_in);
        chk("done", done, e.done);
        chk("illegal", illegal, e.ill);
        chk("alu_oc", alu_oc, m_oc);
        chk("alu_b", alu_b, m_b);
        chk("retired", retired, m_ret);
        if (reg_ld) begin n_ld++; last_ld_in = reg_in; end
        if (reg_inc) n_inc++;
        if (reg_dec) n_dec++;
        if (reg_sl) n_sl++;
        if (done) n_done++;
        if (illegal) n_ill++;
        if (reg_cl | reg_ld | reg_inc | reg_dec | reg_sr | reg_sl) n_stb++;
    endtask

    // Every cycle passes through here: check at negedge, advance the model at posedge, drive at +1.
    task automatic tick();
        @(negedge clk);
        cmp();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic clr_cnt();
        n_ld = 0; n_inc = 0; n_dec = 0; n_sl = 0; n_done = 0; n_ill = 0; n_stb = 0;
    endtask

    task automatic issue(input logic [7:0] i);
        int n;
        n = 0;
        instr = i;
        instr_valid = 1'b1;
        while (!instr_ready && n < 40) begin tick(); n++; end
        chk("issue_wait", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        instr = 8'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!instr_ready && n < 40) begin tick(); n++; end
        chk("idle_wait", instr_ready, 1);
    endtask

    initial begin
        int n, xfers;
        clr_cnt();
        last_ld_in = 4'd0;
        tick();
        tick();
        chk("rst_ready_low", instr_ready, 0);
        chk("rst_retired", retired, 0);
        chk("rst_alu_b", alu_b, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_high", instr_ready, 1);

        // LDI 5, INC, SHL imm=0101
        clr_cnt();
        issue(8'h25); wait_idle(n); chk("ldi_busy", n, 1);
        chk("ldi_value", last_ld_in, 5);
        issue(8'h30); wait_idle(n); chk("inc_busy", n, 1);
        issue(8'h65); wait_idle(n); chk("shl_busy", n, 2);
        chk("t1_ld", n_ld, 1); chk("t1_inc", n_inc, 1); chk("t1_sl", n_sl, 2);
        chk("t1_retired", retired, 3);

        // LDB 3 then ALU oc=0, then ALU oc=6 and a NOP to show alu_oc holds
        alu_f = 4'h8;
        issue(8'h73); wait_idle(n);
        chk("ldb_alu_b", alu_b, 3);
        clr_cnt();
        issue(8'h80); wait_idle(n);
        chk("alu_oc0", alu_oc, 0); chk("alu_ld", n_ld, 1); chk("alu_reg_in", last_ld_in, 8);
        alu_f = 4'hB;
        issue(8'h86); wait_idle(n);
        issue(8'h00); wait_idle(n);
        chk("alu_oc_hold", alu_oc, 6); chk("alu_reg_in2", last_ld_in, 4'hB);
        chk("t2_retired", retired, 7);

        // REPDEC 15, REPINC 0
        clr_cnt();
        issue(8'hAF); wait_idle(n);
        chk("repdec_busy", n, 15); chk("repdec_cnt", n_dec, 15); chk("repdec_done", n_done, 1);
        clr_cnt();
        issue(8'h90); wait_idle(n);
        chk("repinc0_busy", n, 1); chk("repinc0_stb", n_stb, 0); chk("repinc0_done", n_done, 1);

        // illegal opcode
        clr_cnt();
        issue(8'hC7); wait_idle(n);
        chk("ill_cnt", n_ill, 1); chk("ill_done", n_done, 1); chk("ill_stb", n_stb, 0);
        chk("ill_retired", retired, 10);

        // reset during third cycle of REPINC 8
        clr_cnt();
        issue(8'h98);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_ready_low", instr_ready, 0);
        chk("abort_stb_after", reg_inc, 0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_high", instr_ready, 1);
        repeat (3) tick();
        chk("abort_inc", n_inc, 3); chk("abort_done", n_done, 0); chk("abort_retired", retired, 0);

        // 256 back-to-back NOPs
        clr_cnt();
        xfers = 0;
        instr = 8'h00;
        instr_valid = 1'b1;
        repeat (512) begin
            if (instr_ready) xfers++;
            tick();
        end
        instr_valid = 1'b0;
        tick();
        chk("nop_xfers", xfers, 256); chk("nop_done", n_done, 256); chk("nop_wrap", retired, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
